// File: rtl/vga_lectura_pkg.sv
// Shared VGA/RGB332 definitions for the frame-buffer read (lectura) and capture sides.
// Holds default 640x480@60 timing, image size, RAM address width and pixel format.
package vga_lectura_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int IMG_W_D = 320;
    localparam int IMG_H_D = 240;

    localparam int ADDR_W = 17;

    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int PIX_W = R_W + G_W + B_W;

    localparam logic [PIX_W-1:0] BLANK = '0;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb332_t;

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: pixel/line counters, their next values, raw active-low syncs, active flag.
// Ports: clk, rst (sync, high); h_cnt/v_cnt, h_nxt/v_nxt, line_end, hs_raw, vs_raw, active.
module vga_timing
    import vga_lectura_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int HW       = 10,
    parameter int VW       = 10
)(
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic [HW-1:0] h_nxt,
    output logic [VW-1:0] v_nxt,
    output logic          line_end,
    output logic          hs_raw,
    output logic          vs_raw,
    output logic          active
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS   = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS   = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

    always_comb begin
        line_end = (h_cnt == H_LAST);
        h_nxt    = h_cnt + 1'b1;
        v_nxt    = v_cnt;
        if (line_end) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    assign hs_raw = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs_raw = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);

endmodule

// File: rtl/vga_lectura.sv
// Frame-buffer reader: scans a 2x-upscaled RGB332 image out of a dual-port RAM onto VGA.
// Ports: CLK, RST; DP_RAM_addr_out/DP_RAM_data_out (RAM read port); VGA_HS/VS/RGB; FRAME_END.
module vga_lectura
    import vga_lectura_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int IMG_W    = IMG_W_D,
    parameter int IMG_H    = IMG_H_D
)(
    input  logic              CLK,
    input  logic              RST,
    output logic [ADDR_W-1:0] DP_RAM_addr_out,
    input  logic [PIX_W-1:0]  DP_RAM_data_out,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic [PIX_W-1:0]  VGA_RGB,
    output logic              FRAME_END
);

    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    localparam logic [HW-1:0] X_END  = HW'(2 * IMG_W);
    localparam logic [VW-1:0] Y_END  = VW'(2 * IMG_H);
    localparam logic [HW-1:0] X_LAST = HW'(2 * IMG_W - 1);
    localparam logic [VW-1:0] Y_LAST = VW'(2 * IMG_H - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          line_end;
    logic          hs_raw;
    logic          vs_raw;
    logic          active;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk      (CLK),
        .rst      (RST),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .h_nxt    (h_nxt),
        .v_nxt    (v_nxt),
        .line_end (line_end),
        .hs_raw   (hs_raw),
        .vs_raw   (vs_raw),
        .active   (active)
    );

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] base_nxt;
    logic [ADDR_W-1:0] col;
    logic              img_cur;
    logic              img_nxt;
    logic              pix_ok;
    logic              hs_d;
    logic              vs_d;
    logic              hs_q;
    logic              vs_q;
    rgb332_t           rgb_q;
    logic              fe_q;

    // row_base always holds the RAM row of the line now on the counters.
    // Odd image lines advance it, so every RAM row is drawn twice.
    always_comb begin
        base_nxt = row_base;
        if (line_end) begin
            if (v_nxt == '0)
                base_nxt = '0;
            else if (v_cnt[0] && (v_cnt < Y_LAST))
                base_nxt = row_base + ADDR_W'(IMG_W);
        end
    end

    assign col     = ADDR_W'(h_nxt[HW-1:1]);
    assign img_cur = (h_cnt < X_END) && (v_cnt < Y_END);
    assign img_nxt = (h_nxt < X_END) && (v_nxt < Y_END);

    // The address register is loaded from the next counter position, so it
    // shows the address of the pixel currently on the counters. With the one
    // CLK RAM read and the colour register this gives 2 CLK counter-to-pin.
    always_ff @(posedge CLK) begin
        if (RST) begin
            row_base        <= '0;
            DP_RAM_addr_out <= '0;
            pix_ok          <= 1'b0;
            hs_d            <= 1'b1;
            vs_d            <= 1'b1;
            hs_q            <= 1'b1;
            vs_q            <= 1'b1;
            rgb_q           <= rgb332_t'(BLANK);
            fe_q            <= 1'b0;
        end else begin
            row_base <= base_nxt;
            if (img_nxt)
                DP_RAM_addr_out <= base_nxt + col;
            pix_ok <= active && img_cur;
            hs_d   <= hs_raw;
            vs_d   <= vs_raw;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            rgb_q  <= pix_ok ? rgb332_t'(DP_RAM_data_out)
                             : rgb332_t'(BLANK);
            fe_q   <= (h_nxt == X_LAST) && (v_nxt == Y_LAST);
        end
    end

    assign VGA_HS    = hs_q;
    assign VGA_VS    = vs_q;
    assign VGA_RGB   = rgb_q;
    assign FRAME_END = fe_q;

endmodule

// File: tb/tb_vga_lectura.sv
// Scoreboard bench for vga_lectura: default timing plus two reduced-size
// instances (full image and small image) so whole frames fit in a short run.
module tb_vga_lectura;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [16:0] addr [3];
    logic [7:0]  din  [3];
    logic        hs   [3];
    logic        vs   [3];
    logic [7:0]  rgb  [3];
    logic        fe   [3];

    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            din[i] <= addr[i][7:0];

    vga_lectura u_dut0 (
        .CLK(clk), .RST(rst),
        .DP_RAM_addr_out(addr[0]), .DP_RAM_data_out(din[0]),
        .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_RGB(rgb[0]),
        .FRAME_END(fe[0])
    );

    vga_lectura #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .IMG_W(16), .IMG_H(12)
    ) u_dut1 (
        .CLK(clk), .RST(rst),
        .DP_RAM_addr_out(addr[1]), .DP_RAM_data_out(din[1]),
        .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_RGB(rgb[1]),
        .FRAME_END(fe[1])
    );

    vga_lectura #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .IMG_W(8), .IMG_H(6)
    ) u_dut2 (
        .CLK(clk), .RST(rst),
        .DP_RAM_addr_out(addr[2]), .DP_RAM_data_out(din[2]),
        .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_RGB(rgb[2]),
        .FRAME_END(fe[2])
    );

    int ha  [3] = '{640, 32, 32};
    int hf  [3] = '{16, 4, 4};
    int hsy [3] = '{96, 8, 8};
    int hb  [3] = '{48, 4, 4};
    int va  [3] = '{480, 24, 24};
    int vf  [3] = '{10, 2, 2};
    int vsy [3] = '{2, 2, 2};
    int vb  [3] = '{33, 4, 4};
    int iw  [3] = '{320, 16, 8};
    int ih  [3] = '{240, 12, 6};

    int mh [3];
    int mv [3];
    int ea [3];
    int mx [3];
    int fe_cnt [3];

    int   cyc = 0;
    int   hs_fall = -1;
    int   vs_fall = -1;
    logic hs_prev = 1'b1;
    logic vs_prev = 1'b1;
    int   found;

    typedef struct {
        int         id;
        logic       hs;
        logic       vs;
        logic [7:0] rgb;
    } exp_t;

    exp_t q[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_now(input int i);
        int   h;
        int   v;
        logic img;
        logic act;
        exp_t e;
        h   = mh[i];
        v   = mv[i];
        img = (h < 2 * iw[i]) && (v < 2 * ih[i]);
        act = (h < ha[i]) && (v < va[i]);
        if (img)
            ea[i] = (v / 2) * iw[i] + h / 2;
        e.id  = i;
        e.hs  = !((h >= ha[i] + hf[i]) && (h < ha[i] + hf[i] + hsy[i]));
        e.vs  = !((v >= va[i] + vf[i]) && (v < va[i] + vf[i] + vsy[i]));
        e.rgb = (img && act) ? 8'(ea[i]) : 8'h00;
        q.push_back(e);
    endtask

    task automatic advance(input int i);
        mh[i]++;
        if (mh[i] == ha[i] + hf[i] + hsy[i] + hb[i]) begin
            mh[i] = 0;
            mv[i]++;
            if (mv[i] == va[i] + vf[i] + vsy[i] + vb[i])
                mv[i] = 0;
        end
    endtask

    task automatic step();
        exp_t e;
        cyc++;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rst_addr%0d", i), int'(addr[i]), 0);
                chk($sformatf("rst_hs%0d", i), int'(hs[i]), 1);
                chk($sformatf("rst_vs%0d", i), int'(vs[i]), 1);
                chk($sformatf("rst_rgb%0d", i), int'(rgb[i]), 0);
                chk($sformatf("rst_fe%0d", i), int'(fe[i]), 0);
                mh[i] = 0;
                mv[i] = 0;
                ea[i] = 0;
                e.id  = i;
                e.hs  = 1'b1;
                e.vs  = 1'b1;
                e.rgb = 8'h00;
                q.push_back(e);
            end
            for (int i = 0; i < 3; i++) begin
                push_now(i);
                advance(i);
            end
            hs_fall = -1;
            vs_fall = -1;
            hs_prev = 1'b1;
            vs_prev = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                push_now(i);
                chk($sformatf("addr%0d", i), int'(addr[i]), ea[i]);
                chk($sformatf("fe%0d", i), int'(fe[i]),
                    int'(mh[i] == 2 * iw[i] - 1 && mv[i] == 2 * ih[i] - 1));
                if (int'(addr[i]) > mx[i])
                    mx[i] = int'(addr[i]);
                if (fe[i])
                    fe_cnt[i]++;
            end
            if (mv[0] == 0 && mh[0] == 2)
                chk("addr_2_0", int'(addr[0]), 1);
            if (mv[0] == 0 && mh[0] == 3)
                chk("addr_3_0", int'(addr[0]), 1);
            if (mv[0] == 1 && mh[0] == 0)
                chk("addr_0_1", int'(addr[0]), 0);
            if (mv[0] == 2 && mh[0] == 0)
                chk("addr_0_2", int'(addr[0]), 320);
            if (mv[0] == 0 && mh[0] == 6)
                chk("rgb_4_0", int'(rgb[0]), 2);
            if (mv[0] == 0 && mh[0] == 702)
                chk("rgb_blank", int'(rgb[0]), 0);
            if (mv[1] == 23 && mh[1] == 31)
                chk("addr_last1", int'(addr[1]), 191);
            if (mv[2] == 0 && mh[2] == 18)
                chk("rgb_outx2", int'(rgb[2]), 0);
            if (mv[2] == 14 && mh[2] == 2)
                chk("rgb_outy2", int'(rgb[2]), 0);
            if (mv[2] == 11 && mh[2] == 15)
                chk("addr_last2", int'(addr[2]), 47);
            for (int k = 0; k < 3; k++) begin
                e = q.pop_front();
                chk($sformatf("hs%0d", e.id), int'(hs[e.id]), int'(e.hs));
                chk($sformatf("vs%0d", e.id), int'(vs[e.id]), int'(e.vs));
                chk($sformatf("rgb%0d", e.id), int'(rgb[e.id]), int'(e.rgb));
            end
            if (hs_prev && !hs[0]) begin
                if (hs_fall >= 0)
                    chk("hs_period", cyc - hs_fall, 800);
                hs_fall = cyc;
            end
            if (!hs_prev && hs[0] && hs_fall >= 0)
                chk("hs_low", cyc - hs_fall, 96);
            if (vs_prev && !vs[1]) begin
                if (vs_fall >= 0)
                    chk("vs_period1", cyc - vs_fall, 1536);
                vs_fall = cyc;
            end
            if (!vs_prev && vs[1] && vs_fall >= 0)
                chk("vs_low1", cyc - vs_fall, 96);
            hs_prev = hs[0];
            vs_prev = vs[1];
            for (int i = 0; i < 3; i++)
                advance(i);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mh[i]     = 0;
            mv[i]     = 0;
            ea[i]     = 0;
            mx[i]     = 0;
            fe_cnt[i] = 0;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            step();
        end
        rst = 1'b0;
        repeat (2500) begin
            @(negedge clk);
            step();
        end

        found = 0;
        for (int k = 0; k < 2000 && found == 0; k++) begin
            @(negedge clk);
            if (mh[1] == 20 && mv[1] == 16)
                found = 1;
            step();
        end
        chk("rst_point", found, 1);

        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            fe_cnt[i] = 0;
        @(negedge clk);
        step();
        rst = 1'b0;
        chk("post_rst_v1", mv[1], 0);
        repeat (4607) begin
            @(negedge clk);
            step();
        end

        chk("fe_count1", fe_cnt[1], 3);
        chk("fe_count2", fe_cnt[2], 3);
        chk("max_addr1", mx[1], 191);
        chk("max_addr2", mx[2], 47);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vga_lectura.md
VGA_LECTURA -- requirements
Module: vga_lectura

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter IMG_W / IMG_H, 320 / 240, stored image size in RAM pixels; each is scaled 2x on screen.
REQ-006 CLK  in  1  25 MHz pixel clock; single clock domain.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 DP_RAM_addr_out  out  17  read address to the dual-port RAM read port.
REQ-009 DP_RAM_data_out  in  8  RGB332 pixel returned by the RAM one CLK after the address.
REQ-010 VGA_HS  out  1  horizontal sync, active-low.
REQ-011 VGA_VS  out  1  vertical sync, active-low.
REQ-012 VGA_RGB  out  8  RGB332 pixel: [7:5] R, [4:2] G, [1:0] B.
REQ-013 FRAME_END  out  1  one-CLK pulse when the last active pixel of a frame is issued.

Function
REQ-014 Counters h_cnt 0..799 and v_cnt 0..524 (derived from parameters); h_cnt wraps to 0 and v_cnt increments on h_cnt = 799; v_cnt wraps to 0 on 524 with h_cnt = 799.
REQ-015 Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-016 Image region: h_cnt < 2*IMG_W and v_cnt < 2*IMG_H; active pixels outside it output 0x00.
REQ-017 Raw HS low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); raw VS low for lines 490..491.
REQ-018 Address generation without a multiplier: row_base register plus column counter; addr = row_base + (h_cnt >> 1).
REQ-019 row_base resets to 0 at v_cnt = 0 and advances by IMG_W at the end of each odd image line (v_cnt[0] = 1), so each RAM row is shown twice.
REQ-020 DP_RAM_addr_out is registered (stage 1); it holds its last value outside the image region.
REQ-021 RAM data returns at stage 2; VGA_RGB is registered from it (stage 3) and forced to 0x00 when the delayed active/image flag is 0.
REQ-022 VGA_HS, VGA_VS and active/image flags are delayed through the same 2-stage pipeline so VGA_HS/VGA_VS/VGA_RGB stay aligned; fixed latency from counter to pins is 2 CLK.
REQ-023 FRAME_END pulses for exactly one CLK, coincident with the address 2*... last image pixel (addr = IMG_W*IMG_H-1) leaving stage 1.
REQ-024 Address never exceeds IMG_W*IMG_H-1 (76799); no reads are issued outside the image region.

Reset
REQ-025 On RST = 1 at a CLK edge: h_cnt = 0, v_cnt = 0, row_base = 0, DP_RAM_addr_out = 0, pipeline flags cleared, VGA_HS = 1, VGA_VS = 1, VGA_RGB = 0x00, FRAME_END = 0.
REQ-026 Reset asserted mid-frame aborts the frame; the first CLK after RST deasserts is h_cnt = 0, v_cnt = 0 of a fresh frame.

Structure
REQ-027 Timing parameters, RGB332 field widths and the blank value 0x00 belong in a shared package/include used also by the capture side.
REQ-028 One sub-module, vga_timing (counters, raw sync, active flag); vga_lectura adds addressing, pipeline and colour output.

Verification
REQ-029 Reset then run 420000 CLK: VGA_HS period 800 CLK with 96-CLK low pulse; VGA_VS period 420000 CLK with 1600-CLK low pulse.
REQ-030 Address check: screen (0,0) -> 0, (2,0) -> 1, (3,0) -> 1, (0,1) -> 0, (0,2) -> 320, (639,479) -> 76799.
REQ-031 RAM model returns addr[7:0]; at screen (4,0) VGA_RGB = 0x02 exactly 2 CLK after that counter value; during blanking VGA_RGB = 0x00.
REQ-032 IMG_W = 160, IMG_H = 120: pixels at h_cnt >= 320 or v_cnt >= 240 output 0x00 and max address = 19199.
REQ-033 RST pulsed at v_cnt = 300, h_cnt = 400: outputs reach reset values next CLK; next frame addresses start at 0 and FRAME_END pulses once per frame only.
